// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry and architectural register aliases.
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] R_SP     = 5'd29;
    localparam logic [REG_ADDR_W-1:0] R_RA     = 5'd31;
endpackage

// File: rtl/regfile_rdport.sv
// One combinational register-file read port: r0 forced to zero, optional same-cycle write bypass.
module regfile_rdport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] data
);
    always_comb begin
        data = '0;
        // Reset and r0 both read as zero; bypass must never override either.
        if (!rst && (addr != '0)) begin
            if (BYPASS && we && (waddr == addr)) begin
                data = wdata;
            end else begin
                data = stored;
            end
        end
    end
endmodule

// File: rtl/id_regfile.sv
// ID-stage GPR file: write-back port from WR, two bypassed read ports, one raw debug port.
module id_regfile
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::REG_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IDin_Ra,
    input  logic [ADDR_W-1:0] IDin_Rb,
    input  logic [DATA_W-1:0] IDin_RegDin,
    input  logic [ADDR_W-1:0] IDin_Rw,
    input  logic              IDin_RegWE,
    input  logic [ADDR_W-1:0] IDin_DbgAddr,
    output logic [DATA_W-1:0] IDout_BusA,
    output logic [DATA_W-1:0] IDout_BusB,
    output logic [DATA_W-1:0] IDout_DbgData
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_en;

    // r0 is never written, so its flop stays at the reset value of zero.
    assign wr_en = IDin_RegWE && (IDin_Rw != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[IDin_Rw] = IDin_RegDin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign IDout_DbgData = rst ? '0 : regs_q[IDin_DbgAddr];

    regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_a (
        .rst    (rst),
        .addr   (IDin_Ra),
        .stored (regs_q[IDin_Ra]),
        .we     (IDin_RegWE),
        .waddr  (IDin_Rw),
        .wdata  (IDin_RegDin),
        .data   (IDout_BusA)
    );

    regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port_b (
        .rst    (rst),
        .addr   (IDin_Rb),
        .stored (regs_q[IDin_Rb]),
        .we     (IDin_RegWE),
        .waddr  (IDin_Rw),
        .wdata  (IDin_RegDin),
        .data   (IDout_BusB)
    );
endmodule

// File: tb/tb_id_regfile.sv
// Bench for id_regfile: bypassing and non-bypassing instances share stimulus and a behavioural model.
module tb_id_regfile;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  ra, rb, rw, dbg;
    logic [31:0] din;
    logic        we;
    logic [31:0] a_byp, b_byp, d_byp;
    logic [31:0] a_nob, b_nob, d_nob;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model [32];

    id_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst),
        .IDin_Ra(ra), .IDin_Rb(rb), .IDin_RegDin(din), .IDin_Rw(rw),
        .IDin_RegWE(we), .IDin_DbgAddr(dbg),
        .IDout_BusA(a_byp), .IDout_BusB(b_byp), .IDout_DbgData(d_byp)
    );

    id_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst(rst),
        .IDin_Ra(ra), .IDin_Rb(rb), .IDin_RegDin(din), .IDin_Rw(rw),
        .IDin_RegWE(we), .IDin_DbgAddr(dbg),
        .IDout_BusA(a_nob), .IDout_BusB(b_nob), .IDout_DbgData(d_nob)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural register file: an array of 32 words, cleared whenever reset is high
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we === 1'b1 && rw != 5'd0) begin
            model[rw] = din;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (rst) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && we === 1'b1 && rw == a) return din;
        return model[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // continuous compare on the falling edge, away from the write edge
    always @(negedge clk) begin
        chk("busa_byp", a_byp, exp_read(ra, 1'b1));
        chk("busb_byp", b_byp, exp_read(rb, 1'b1));
        chk("dbg_byp",  d_byp, rst ? 32'h0 : model[dbg]);
        chk("busa_nob", a_nob, exp_read(ra, 1'b0));
        chk("busb_nob", b_nob, exp_read(rb, 1'b0));
        chk("dbg_nob",  d_nob, rst ? 32'h0 : model[dbg]);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic e, input logic [4:0] addr, input logic [31:0] data);
        we  = e;
        rw  = addr;
        din = data;
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        ra  = a;
        rb  = b;
        dbg = d;
    endtask

    initial begin
        rst = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd0, 5'd0);
        step();
        step();
        #2 rst = 1'b0;
        step();

        // reset clears a written register, asynchronously
        set_wr(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd5, 5'd5);
        #1 chk("r5_written", a_byp, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1 chk("rst_busa_now", a_byp, 32'h0);
        chk("rst_dbg_now", d_byp, 32'h0);
        step();
        #2 rst = 1'b0;
        #1 chk("rst_busa_after", a_byp, 32'h0);
        chk("rst_dbg_after", d_nob, 32'h0);
        step();

        // r0 is hardwired to zero, even when bypassed
        set_wr(1'b1, 5'd0, 32'h12345678);
        set_rd(5'd0, 5'd0, 5'd0);
        #1 chk("r0_bypass", a_byp, 32'h0);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        #1 chk("r0_dbg", d_byp, 32'h0);

        // same-cycle bypass versus stored-value read
        set_wr(1'b1, 5'd7, 32'h1111);
        step();
        set_wr(1'b1, 5'd7, 32'h2222);
        set_rd(5'd7, 5'd7, 5'd7);
        #1 chk("byp_busa", a_byp, 32'h2222);
        chk("byp_busb", b_byp, 32'h2222);
        chk("byp_dbg_before", d_byp, 32'h1111);
        chk("nob_busa_before", a_nob, 32'h1111);
        chk("nob_busb_before", b_nob, 32'h1111);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        #1 chk("byp_dbg_after", d_byp, 32'h2222);
        chk("nob_busa_after", a_nob, 32'h2222);

        // independent ports
        set_wr(1'b1, 5'd1, 32'hA);
        step();
        set_wr(1'b1, R_RA, 32'hB);
        step();
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd1, R_RA, R_SP);
        #1 chk("port_a_r1", a_nob, 32'hA);
        chk("port_b_r31", b_nob, 32'hB);
        chk("dbg_sp", d_nob, 32'h0);

        // writes during reset are ignored
        rst = 1'b1;
        set_wr(1'b1, 5'd3, 32'h55);
        set_rd(5'd3, 5'd3, 5'd3);
        step();
        rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        #1 chk("rst_write_dbg", d_byp, 32'h0);
        step();
        chk("rst_write_busa", a_byp, 32'h0);

        // randomized traffic with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            set_wr(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
            set_rd(($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)));
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
            step();
        end

        set_wr(1'b0, 5'd0, 32'h0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_regfile.md
Name: id_regfile

Overview:
- Register file in the ID stage. It is the receiving end of the write-back interface: it consumes RegDin, Rw and RegWE from the WR stage.
- Holds 32 architectural GPRs.
- Provides two combinational read ports (BusA and BusB) to the ID/EX register, plus one debug read port.
- Optional internal write-to-read bypass. With it, an instruction in ID sees a value that WR is committing in the same cycle, so WR-to-ID forwarding is not needed elsewhere.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (2^ADDR_W registers).
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns the stored value only.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- IDin_Ra  input  ADDR_W  read port A address (rs).
- IDin_Rb  input  ADDR_W  read port B address (rt).
- IDin_RegDin  input  DATA_W  write data from WR stage.
- IDin_Rw  input  ADDR_W  write address from WR stage.
- IDin_RegWE  input  1  write enable from WR stage.
- IDin_DbgAddr  input  ADDR_W  debug read address.
- IDout_BusA  output  DATA_W  read data A.
- IDout_BusB  output  DATA_W  read data B.
- IDout_DbgData  output  DATA_W  debug read data (stored value, never bypassed).

Behaviour:
- Reset:
  - While rst=1, all 2^ADDR_W registers clear to 0 immediately, with no clock edge needed.
  - All three outputs read 0 while rst=1. Bypass is suppressed and writes are ignored.
- Deassertion of rst mid-cycle: the first write is accepted at the next rising clk edge.
- Write:
  - At rising clk, if rst=0, IDin_RegWE=1 and IDin_Rw!=0, then reg[IDin_Rw] <= IDin_RegDin.
  - Writes to address 0 are discarded. reg[0] reads as 0 always.
  - Latency: stored value visible on the debug port one cycle after the write edge.
- Read, combinational, zero latency:
  - BusA = 0 if IDin_Ra==0.
  - Otherwise, BusA = IDin_RegDin if BYPASS=1, IDin_RegWE=1 and IDin_Rw==IDin_Ra.
  - Otherwise, BusA = reg[IDin_Ra].
  - BusB follows the same rule with IDin_Rb.
- Simultaneous events:
  - Ra==Rb: both ports return the identical value.
  - Ra==Rb==Rw with WE=1 and BYPASS=1: both ports return RegDin.
  - Bypass to address 0 never happens: write-to-zero with WE=1 still reads 0.
- BYPASS=0: a read of Rw in the write cycle returns the old value. The new value appears after the edge.
- Unknown or X on IDin_RegWE is treated as no write by the bench. The RTL makes no guarantee for X.
- No overflow gating here. Suppressing RegWE on overflow is the WR stage's responsibility.

Decomposition:
- Shared package cpu_pkg:
  - REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0.
  - Register alias constants (R_SP=29, R_RA=31) used by the debug bench.
- One natural sub-module: regfile_rdport. It holds the zero-check and bypass mux for a single read port, parameterised by DATA_W, ADDR_W and BYPASS. It is instantiated twice, for A and B.
- Storage array and write logic stay in id_regfile.

Test Plan:
1. Reset clears:
   - Stimulus: write 0xDEADBEEF to r5, then pulse rst asynchronously mid-cycle.
   - Required: BusA(Ra=5)=0 immediately during rst and after release; DbgData(5)=0.
2. r0 hardwired:
   - Stimulus: WE=1, Rw=0, RegDin=0x12345678, Ra=0.
   - Required: BusA=0 in that cycle; DbgData(0)=0 next cycle.
3. Bypass (BYPASS=1):
   - Stimulus: r7 holds 0x1111; in one cycle drive WE=1, Rw=7, RegDin=0x2222, Ra=Rb=7.
   - Required: BusA=BusB=0x2222 in the same cycle; DbgData(7)=0x1111 before the edge and 0x2222 after it.
4. No bypass (BYPASS=0):
   - Stimulus: same as scenario 3.
   - Required: BusA=0x1111 before the edge and 0x2222 after it.
5. Independent ports:
   - Stimulus: write r1=0xA, r31=0xB on consecutive cycles; then Ra=1, Rb=31 with WE=0.
   - Required: BusA=0xA, BusB=0xB.
6. Write during reset ignored:
   - Stimulus: rst=1 across a clk edge with WE=1, Rw=3, RegDin=0x55; release rst.
   - Required: DbgData(3)=0.
